// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS Harvard-to-shared-memory arbiter.
//   arb_state_t          arbiter FSM state encoding
//   ARB_TIMEOUT_DEFAULT  default waitrequest timeout, in cycles
// Optional feature macro: ARB_TIMEOUT_EN adds the HALT state, which is entered on a bus timeout.
package mips_pkg;

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        COMMIT = 2'd2,
        HALT   = 2'd3
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        COMMIT = 2'd2
    } arb_state_t;
`endif

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/harvard_mem_arbiter.sv
// Arbiter that connects a Harvard MIPS CPU to a single shared Avalon-style memory.
// For each CPU step it performs an instruction fetch and then an optional data access. It
// pulses clk_enable for one cycle to let the CPU commit the step.
// Ports:
//   clk, reset                   system clock, synchronous active-high reset
//   clk_enable                   CPU advance strobe, one cycle per instruction
//   instr_address/instr_readdata CPU fetch port; the fetched word is latched
//   data_address/read/write/     CPU data port; load data is latched
//     writedata/readdata
//   mem_address/read/write/      shared memory master port
//     writedata/waitrequest/readdata
//   bus_error                    sticky timeout flag
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a waitrequest that stays high
// for TIMEOUT_CYCLES cycles drops the command, sets bus_error and parks the FSM in HALT.
module harvard_mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        bus_error
);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    logic        r_clk_enable;
    logic [31:0] r_instr_readdata;
    logic [31:0] r_data_readdata;
    logic        w_instr_capture;
    logic        w_data_capture;

`ifdef ARB_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_wait_cnt;
    logic        r_bus_error;
    logic        w_busy;
    logic        w_timeout;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        w_state_next    = r_state;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = instr_address;
        mem_writedata   = data_writedata;
        w_instr_capture = 1'b0;
        w_data_capture  = 1'b0;
        case (r_state)
            FETCH: begin
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    w_instr_capture = 1'b1;
                    w_state_next    = DATA;
                end
            end
            DATA: begin
                // A write takes priority; a simultaneous read request is ignored.
                if (data_write) begin
                    mem_write   = 1'b1;
                    mem_address = data_address;
                    if (!mem_waitrequest) w_state_next = COMMIT;
                end else if (data_read) begin
                    mem_read    = 1'b1;
                    mem_address = data_address;
                    if (!mem_waitrequest) begin
                        w_data_capture = 1'b1;
                        w_state_next   = COMMIT;
                    end
                end else begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: w_state_next = FETCH;
`ifdef ARB_TIMEOUT_EN
            HALT:   w_state_next = HALT;
`endif
            default: w_state_next = FETCH;
        endcase

`ifdef ARB_TIMEOUT_EN
        w_busy    = (r_state == FETCH) || ((r_state == DATA) && (data_read || data_write));
        w_timeout = w_busy && mem_waitrequest && (r_wait_cnt == TimeoutLast);
        if (w_timeout) w_state_next = HALT;
`endif

        // Commands drop as soon as the FSM is held in reset.
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= FETCH;
            r_clk_enable     <= 1'b0;
            r_instr_readdata <= 32'h0;
            r_data_readdata  <= 32'h0;
        end else begin
            r_state      <= w_state_next;
            // The strobe is registered so that it is high exactly while the FSM is in COMMIT.
            r_clk_enable <= (w_state_next == COMMIT);
            if (w_instr_capture) r_instr_readdata <= mem_readdata;
            if (w_data_capture)  r_data_readdata  <= mem_readdata;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= 32'h0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_busy) begin
                r_wait_cnt <= mem_waitrequest ? r_wait_cnt + 32'd1 : 32'h0;
            end
            if (w_timeout) r_bus_error <= 1'b1;
        end
    end
    assign bus_error = r_bus_error;
`else
    assign bus_error = 1'b0;
`endif

    assign clk_enable     = r_clk_enable;
    assign instr_readdata = r_instr_readdata;
    assign data_readdata  = r_data_readdata;

endmodule

// File: tb/tb_harvard_mem_arbiter.sv
// Directed self-checking bench for harvard_mem_arbiter, using a scoreboard queue of expected
// latched results and a queue of expected memory writes.
module tb_harvard_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        bus_error;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] drd;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_wr_q[$];
    logic [63:0] wr_q[$];
    logic [31:0] model_drd;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    harvard_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_enable      (clk_enable),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_readdata   (data_readdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .bus_error       (bus_error)
    );

    assign mem_readdata = mem[mem_address[7:2]];

    // Record every accepted write.
    always @(posedge clk) begin
        if (!reset && mem_write && !mem_waitrequest) wr_q.push_back({mem_address, mem_writedata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes();
        logic [63:0] got;
        logic [63:0] want;
        check("wr_count", 32'(wr_q.size()), 32'(exp_wr_q.size()));
        while (wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            got  = wr_q.pop_front();
            want = exp_wr_q.pop_front();
            check("wr_addr", got[63:32], want[63:32]);
            check("wr_data", got[31:0], want[31:0]);
        end
        wr_q.delete();
        exp_wr_q.delete();
    endtask

    // One complete instruction with fw fetch wait cycles and dw data wait cycles.
    task automatic run_instr(input logic [31:0] iaddr, input logic dread, input logic dwrite,
                             input logic [31:0] daddr, input logic [31:0] wdata,
                             input int fw, input int dw);
        exp_t e;
        logic op;
        int   dlen;
        int   total;
        int   dc;
        instr_address  = iaddr;
        data_read      = dread;
        data_write     = dwrite;
        data_address   = daddr;
        data_writedata = wdata;
        e.instr   = mem[iaddr[7:2]];
        e.drd     = (dread && !dwrite) ? mem[daddr[7:2]] : model_drd;
        model_drd = e.drd;
        exp_q.push_back(e);
        if (dwrite) exp_wr_q.push_back({daddr, wdata});
        op    = dread || dwrite;
        dlen  = op ? dw + 1 : 1;
        total = fw + 1 + dlen + 1;
        for (int c = 1; c <= total; c++) begin
            if (c <= fw + 1) begin
                mem_waitrequest = (c <= fw);
                #1;
                check("fetch_read", 32'(mem_read), 32'd1);
                check("fetch_write", 32'(mem_write), 32'd0);
                check("fetch_addr", mem_address, iaddr);
            end else if (c <= fw + 1 + dlen) begin
                dc = c - fw - 1;
                mem_waitrequest = op && (dc <= dw);
                #1;
                check("data_write", 32'(mem_write), 32'(dwrite));
                check("data_read", 32'(mem_read), 32'(dread && !dwrite));
                check("data_addr", mem_address, op ? daddr : iaddr);
                if (dwrite) check("data_wdata", mem_writedata, wdata);
            end else begin
                mem_waitrequest = 1'b0;
                #1;
                check("commit_cmd", 32'({mem_read, mem_write}), 32'd0);
                e = exp_q.pop_front();
                check("instr_readdata", instr_readdata, e.instr);
                check("data_readdata", data_readdata, e.drd);
                check("bus_error", 32'(bus_error), 32'd0);
                check_writes();
            end
            check("clk_enable", 32'(clk_enable), 32'(c == total));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        check("rst_clk_enable", 32'(clk_enable), 32'd0);
        check("rst_cmd", 32'({mem_read, mem_write}), 32'd0);
        check("rst_instr", instr_readdata, 32'h0);
        check("rst_drd", data_readdata, 32'h0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        reset = 1'b0;
        model_drd = 32'h0;
        wr_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[4]  = 32'h8C02_0004;  // 0x10: lw
        mem[1]  = 32'hCAFE_BABE;  // 0x04
        mem[5]  = 32'hAC03_0008;  // 0x14: sw
        mem[6]  = 32'h0022_1820;  // 0x18: add
        mem[7]  = 32'hAC04_0004;  // 0x1C: both requests raised
        mem[9]  = 32'h1234_ABCD;  // 0x24
        instr_address   = 32'h0;
        data_address    = 32'h0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_writedata  = 32'h0;
        mem_waitrequest = 1'b0;
        model_drd       = 32'h0;
        reset           = 1'b1;
        step();
        do_reset(2);

        // Zero-wait load.
        run_instr(32'h10, 1'b1, 1'b0, 32'h04, 32'h0, 0, 0);
        // Store with 2 fetch waits and 3 data waits.
        run_instr(32'h14, 1'b0, 1'b1, 32'h08, 32'h1234_5678, 2, 3);
        // ALU op: no data command.
        run_instr(32'h18, 1'b0, 1'b0, 32'h40, 32'h0, 0, 0);
        // Read and write together: the write wins.
        run_instr(32'h1C, 1'b1, 1'b1, 32'h04, 32'hDEAD_BEEF, 0, 1);
        // Load with waits from a different word.
        run_instr(32'h10, 1'b1, 1'b0, 32'h24, 32'h0, 1, 2);

        // Reset during a stalled store.
        instr_address   = 32'h14;
        data_write      = 1'b1;
        data_read       = 1'b0;
        data_address    = 32'h30;
        data_writedata  = 32'h5555_AAAA;
        mem_waitrequest = 1'b0;
        step();
        mem_waitrequest = 1'b1;
        #1;
        check("mid_write", 32'(mem_write), 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_write", 32'(mem_write), 32'd0);
        check("mid_rst_read", 32'(mem_read), 32'd0);
        check("mid_rst_instr", instr_readdata, 32'h0);
        check("mid_rst_drd", data_readdata, 32'h0);
        check("mid_rst_wr_count", 32'(wr_q.size()), 32'd0);
        do_reset(1);
        data_write = 1'b0;
        // The first instruction after reset starts in FETCH.
        run_instr(32'h10, 1'b1, 1'b0, 32'h04, 32'h0, 0, 0);

`ifdef ARB_TIMEOUT_EN
        instr_address   = 32'h10;
        mem_waitrequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("to_read", 32'(mem_read), 32'd1);
            check("to_bus_error_pre", 32'(bus_error), 32'd0);
            step();
        end
        for (int c = 0; c < 8; c++) begin
            check("to_bus_error", 32'(bus_error), 32'd1);
            check("to_cmd", 32'({mem_read, mem_write}), 32'd0);
            check("to_clk_enable", 32'(clk_enable), 32'd0);
            step();
        end
        do_reset(1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
